// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU.
//
// Accepts one operation at a time on a valid/ready input channel. Simple
// ops finish in one cycle; MUL runs a shift-add sequence and DIV a
// restoring-divide sequence, one bit per cycle over WIDTH cycles. The
// result and flags stay on a valid/ready output channel until taken.
//
// Optional feature macro: ALU_SEQ_DIV_EN builds the iterative divider.
// Without it, opcode 12 is a single-cycle op that returns q=0 and no flags.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   input handshake (in_ready only in IDLE)
//   oper                4-bit opcode
//   operandA/operandB   WIDTH-bit operands, captured on acceptance
//   out_valid/out_ready output handshake
//   q                   WIDTH-bit result
//   flag_zero           q == 0
//   flag_carry          add carry / sub borrow / mul high half nonzero
//   flag_div0           divide by zero
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       oper,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_div0
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_NOT = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam logic [3:0] OP_DIV = 4'd12;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_t           state_q, state_d;
  req_t             req;
  logic [WIDTH-1:0] acc_hi, acc_lo;   // MUL: {partial, multiplier}; DIV: {remainder, quotient}
  logic [SHW-1:0]   cnt;
  logic             fin;              // all iterations done, result write pending
  logic [WIDTH-1:0] q_r;
  logic             z_r, c_r, d0_r;

  function automatic logic is_iter(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return op == OP_MUL;
`endif
  endfunction

  // ---------------------------------------------------------------
  // Single-cycle datapath, evaluated from the captured request in EXEC
  // ---------------------------------------------------------------
  logic [WIDTH:0]   sum, dif;
  logic [SHW-1:0]   shamt;
  logic             shovf;
  logic [WIDTH-1:0] ex_q;
  logic             ex_c;

  assign sum   = {1'b0, req.b} + {1'b0, req.a};
  assign dif   = {1'b0, req.b} - {1'b0, req.a};   // top bit is the borrow (A > B)
  assign shamt = req.b[SHW-1:0];
  assign shovf = (req.b >= W_VAL);

  always_comb begin
    ex_q = '0;
    ex_c = 1'b0;
    case (req.op)
      OP_ADD: begin ex_q = sum[WIDTH-1:0]; ex_c = sum[WIDTH]; end
      OP_SUB: begin ex_q = dif[WIDTH-1:0]; ex_c = dif[WIDTH]; end
      OP_AND: ex_q = req.b & req.a;
      OP_OR:  ex_q = req.b | req.a;
      OP_XOR: ex_q = req.b ^ req.a;
      OP_SHR: ex_q = shovf ? '0 : (req.a >> shamt);
      OP_SHL: ex_q = shovf ? '0 : (req.a << shamt);
      OP_ROR: ex_q = {req.a[0], req.a[WIDTH-1:1]};
      OP_ROL: ex_q = {req.a[WIDTH-2:0], req.a[WIDTH-1]};
      OP_NOT: ex_q = ~req.a;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------
  // One iteration step of the multiplier / divider
  // ---------------------------------------------------------------
  logic [WIDTH:0]   mac;
  logic [WIDTH-1:0] nx_hi, nx_lo;

  // Shift-add: conditionally add A to the partial, then shift the
  // {carry, partial, multiplier} chain right by one.
  assign mac = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, req.a} : '0);

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;

  // Restoring step: shift the next dividend bit into the remainder and
  // subtract B when it fits. The remainder stays below B, so the
  // difference always fits WIDTH bits. With B == 0 every step "fits",
  // which naturally yields an all-ones quotient.
  assign rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
  assign rem_ge  = (rem_sh >= {1'b0, req.b});
  assign rem_sub = rem_sh[WIDTH-1:0] - req.b;
`endif

  always_comb begin
    nx_hi = mac[WIDTH:1];
    nx_lo = {mac[0], acc_lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    if (req.op == OP_DIV) begin
      nx_hi = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
      nx_lo = {acc_lo[WIDTH-2:0], rem_ge};
    end
`endif
  end

  // ---------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = is_iter(oper) ? ITER : EXEC;
      end
      EXEC: state_d = DONE;
      ITER: if (fin) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Capture, iteration and result registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      fin    <= 1'b0;
      q_r    <= '0;
      z_r    <= 1'b0;
      c_r    <= 1'b0;
      d0_r   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          req    <= '{op: oper, a: operandA, b: operandB};
          acc_hi <= '0;
          acc_lo <= (oper == OP_MUL) ? operandB : operandA;
          cnt    <= SHW'(WIDTH - 1);
          fin    <= 1'b0;
        end
        EXEC: begin
          q_r  <= ex_q;
          z_r  <= (ex_q == '0);
          c_r  <= ex_c;
          d0_r <= 1'b0;
        end
        ITER: begin
          if (!fin) begin
            acc_hi <= nx_hi;
            acc_lo <= nx_lo;
            if (cnt == '0) fin <= 1'b1;
            else           cnt <= cnt - SHW'(1);
          end else begin
            // Extra cycle after the last step writes the result, matching
            // the EXEC write for single-cycle ops.
            q_r  <= acc_lo;
            z_r  <= (acc_lo == '0);
            c_r  <= (req.op == OP_MUL) && (acc_hi != '0);
            d0_r <= (req.op == OP_DIV) && (req.b == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign q          = q_r;
  assign flag_zero  = z_r;
  assign flag_carry = c_r;
  assign flag_div0  = d0_r;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=16): directed vectors, an arithmetic reference
// model, a per-cycle compare process, and literal checks on key cases.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   oper = '0;
  logic [W-1:0] operandA = '0, operandB = '0;
  logic         in_ready, out_valid, flag_zero, flag_carry, flag_div0;
  logic [W-1:0] q;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .oper(oper), .operandA(operandA), .operandB(operandB),
    .out_valid(out_valid), .out_ready(out_ready), .q(q),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_div0(flag_div0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  bit started = 0;

  // Outstanding operation as seen by the model
  bit           pend = 0;
  int           pend_t = 0, e_lat = 1;
  logic [W-1:0] e_q = '0;
  logic         e_c = 0, e_d = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model from plain arithmetic on the operation definitions.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, b,
                                output logic [W-1:0] mq, output logic mc, md,
                                output int lat);
    longint unsigned ua, ub, r;
    ua = a; ub = b; r = 0;
    mc = 0; md = 0; lat = 1;
    case (op)
      1:  begin r = ub + ua; mc = (r >> W) != 0; end
      2:  begin r = ub - ua; mc = ua > ub; end
      3:  r = ub & ua;
      4:  r = ub | ua;
      5:  r = ub ^ ua;
      6:  r = (ub >= W) ? 0 : (ua >> ub);
      7:  r = (ub >= W) ? 0 : (ua << ub);
      8:  r = (ua >> 1) | ((ua & 1) << (W - 1));
      9:  r = (ua << 1) | (ua >> (W - 1));
      10: r = ~ua;
      11: begin r = ua * ub; mc = (r >> W) != 0; lat = W + 1; end
`ifdef ALU_SEQ_DIV_EN
      12: begin
        lat = W + 1;
        if (ub == 0) begin r = (64'd1 << W) - 1; md = 1; end
        else r = ua / ub;
      end
`endif
      default: r = 0;
    endcase
    mq = W'(r);
  endfunction

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst && started) begin
      bit ev;
      ev = pend && (cyc >= pend_t + e_lat);
      chk("in_ready", in_ready, !pend);
      chk("out_valid", out_valid, ev);
      if (ev && out_valid) begin
        chk("q", q, e_q);
        chk("flag_zero", flag_zero, e_q == '0);
        chk("flag_carry", flag_carry, e_c);
        chk("flag_div0", flag_div0, e_d);
      end
    end
  end

  // Issue one op; hold<0 raises out_ready right after acceptance,
  // otherwise out_ready is held low for hold cycles after out_valid.
  // busy keeps in_valid asserted with a different op while occupied.
  task automatic run(input logic [3:0] op, input logic [W-1:0] a, b,
                     input int hold, input bit busy,
                     output logic [W-1:0] rq, output logic rz, rc, rd);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("ready_timeout", 0, 1);
    in_valid = 1; oper = op; operandA = a; operandB = b;
    model(op, a, b, e_q, e_c, e_d, e_lat);
    @(posedge clk); #1;
    pend = 1; pend_t = cyc;
    in_valid = busy; oper = 4'd1; operandA = ~a; operandB = ~b;
    out_ready = (hold < 0);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    if (!out_valid) chk("valid_timeout", 0, 1);
    for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
    rq = q; rz = flag_zero; rc = flag_carry; rd = flag_div0;
    out_ready = 1;
    @(posedge clk); #1;
    pend = 0; out_ready = 0; in_valid = 0;
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b;
    int           hold;
    bit           busy;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rq;
    logic rz, rc, rd;
    logic [W-1:0] mq;
    logic mc, md;
    int ml;

    rst = 0;
    #1 rst = 1;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_flags", {flag_zero, flag_carry, flag_div0}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    started = 1;

    // Pin the model itself on a couple of hand-computed cases
    model(4'd2, 16'd5, 16'd3, mq, mc, md, ml);
    chk("model_sub", {mq, mc}, {16'hFFFE, 1'b1});
    model(4'd11, 16'h0100, 16'h0100, mq, mc, md, ml);
    chk("model_mul_lat", ml, 17);

    // ADD wrap
    run(4'd1, 16'h0001, 16'hFFFF, 0, 0, rq, rz, rc, rd);
    chk("add_q", rq, 16'h0000);
    chk("add_zc", {rz, rc}, 2'b11);

    // SHL in range and at WIDTH
    run(4'd7, 16'h0003, 16'd4, 0, 0, rq, rz, rc, rd);
    chk("shl4", rq, 16'h0030);
    run(4'd7, 16'h0003, 16'd16, 0, 0, rq, rz, rc, rd);
    chk("shl16", rq, 16'h0000);

    // Rotates
    run(4'd9, 16'h8001, 16'h0, 0, 0, rq, rz, rc, rd);
    chk("rol1", rq, 16'h0003);
    run(4'd8, 16'h8001, 16'h0, 0, 0, rq, rz, rc, rd);
    chk("ror1", rq, 16'hC000);

    // MUL with back-pressure and in_valid pressed while busy
    run(4'd11, 16'h0100, 16'h0100, 5, 1, rq, rz, rc, rd);
    chk("mul_q", rq, 16'h0000);
    chk("mul_c", rc, 1);

    // DIV
    run(4'd12, 16'd100, 16'd7, 0, 0, rq, rz, rc, rd);
`ifdef ALU_SEQ_DIV_EN
    chk("div_q", rq, 16'd14);
`else
    chk("div_off_q", {rq, rc, rd}, 18'd0);
`endif
    run(4'd12, 16'd100, 16'd0, 2, 0, rq, rz, rc, rd);
`ifdef ALU_SEQ_DIV_EN
    chk("div0_q", rq, 16'hFFFF);
    chk("div0_flag", rd, 1);
`else
    chk("div0_off", {rq, rd}, 17'd0);
`endif

    // Reset in the middle of a MUL
    in_valid = 1; oper = 4'd11; operandA = 16'h1234; operandB = 16'h5678;
    model(4'd11, 16'h1234, 16'h5678, e_q, e_c, e_d, e_lat);
    @(posedge clk); #1;
    pend = 1; pend_t = cyc; in_valid = 0;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1; pend = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_q", q, 0);
    @(posedge clk); #1;
    rst = 0;
    repeat (25) begin @(posedge clk); #1; end

    // Further patterns checked by the model through the compare process
    tbl[0]  = '{4'd2,  16'd5,    16'd3,    0, 0};
    tbl[1]  = '{4'd2,  16'd3,    16'd5,    0, 0};
    tbl[2]  = '{4'd3,  16'hF0F0, 16'hFF00, 1, 0};
    tbl[3]  = '{4'd4,  16'hF0F0, 16'h0F0F, 0, 1};
    tbl[4]  = '{4'd5,  16'hAAAA, 16'hAAAA, 0, 0};
    tbl[5]  = '{4'd6,  16'h8000, 16'd15,   0, 0};
    tbl[6]  = '{4'd6,  16'h8000, 16'd16,   0, 0};
    tbl[7]  = '{4'd7,  16'h0001, 16'hFFFF, 0, 0};
    tbl[8]  = '{4'd10, 16'hFFFF, 16'h1234, 0, 0};
    tbl[9]  = '{4'd0,  16'h1234, 16'h5678, 0, 0};
    tbl[10] = '{4'd13, 16'hFFFF, 16'hFFFF, 0, 0};
    tbl[11] = '{4'd11, 16'h1234, 16'h0056, -1, 0};
    tbl[12] = '{4'd11, 16'hFFFF, 16'hFFFF, 2, 1};
    tbl[13] = '{4'd11, 16'h00FF, 16'h0101, 0, 0};
    tbl[14] = '{4'd12, 16'hFFFF, 16'd1,    0, 0};
    tbl[15] = '{4'd12, 16'd5,    16'd9,    -1, 0};
    tbl[16] = '{4'd1,  16'h7FFF, 16'h0001, -1, 0};
    tbl[17] = '{4'd8,  16'h0001, 16'h0000, 3, 1};
    foreach (tbl[i]) run(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].busy, rq, rz, rc, rd);

    repeat (3) begin @(posedge clk); #1; end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
